systolic_tile_engine: RTL and testbench
=======================================

Name: systolic_tile_engine

Overview:
- Output-stationary ROWS x COLS systolic matrix-multiply tile with internal operand skewing, a valid/ready input stream, and FSM-controlled tile sequencing.
- Computes C = A x B over k_len streamed beats: one A column and one B row per beat.
- After draining, presents a frozen, flat accumulator snapshot with a done pulse.
- Sits between the operand fetch logic and the result writeback in the accelerator datapath.

Parameters:
- ROWS, 4, PE rows (A column length, C rows).
- COLS, 4, PE columns (B row length, C columns).
- OP_WIDTH, 8, operand width.
- ACC_WIDTH, 32, accumulator width; must be >= 2*OP_WIDTH.
- K_WIDTH, 8, width of k_len.
- SIGNED, 0, 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a tile; sampled only in IDLE or DONE
- k_len  in  K_WIDTH  beats in the tile; latched on accepted start
- in_valid  in  1  beat present
- in_ready  out  1  high only in STREAM
- a_column  in  ROWS*OP_WIDTH  A[i][k] at bits [i*OP_WIDTH +: OP_WIDTH]
- b_row  in  COLS*OP_WIDTH  B[k][j] at bits [j*OP_WIDTH +: OP_WIDTH]
- busy  out  1  high in CLEAR, STREAM, DRAIN
- done  out  1  one-cycle pulse on entry to DONE
- result_valid  out  1  high while in DONE
- result  out  ROWS*COLS*ACC_WIDTH  C[i][j] at bits [(i*COLS+j)*ACC_WIDTH +: ACC_WIDTH]

Behaviour:
- Reset: synchronous, active-high. Clock: clk.
- On reset, FSM goes to IDLE. All skew registers, PE operand registers, accumulators, counters and outputs clear to 0, including in_ready, busy, done, result_valid and result.
- Reset mid-operation (any state) aborts the tile with the same effect.
- FSM states:
  - IDLE: start -> CLEAR.
  - CLEAR: lasts 1 cycle. Zeroes all accumulators and pipeline registers, latches k_len. If k_len==0 -> DONE, else -> STREAM.
  - STREAM: in_ready=1. A beat is accepted when in_valid && in_ready. On a cycle with no beat, zero operands are injected so the array advances every cycle. After the k_len-th accepted beat -> DRAIN.
  - DRAIN: zeros are injected for exactly ROWS+COLS-1 cycles, then -> DONE.
  - DONE: result_valid=1 and result is frozen. start -> CLEAR. start in DONE also drops result_valid in the next cycle.
- start is ignored in CLEAR, STREAM and DRAIN.
- Skew: A row i passes through i delay stages and B column j through j delay stages before entering the array. Depth-0 rows and columns enter the PE operand register on the accepting edge.
- Dataflow: A operands move right one PE per cycle and B operands move down one PE per cycle.
  - Each PE computes acc <= acc + ext(a*b) every cycle outside CLEAR.
  - The product is 2*OP_WIDTH wide, sign- or zero-extended per SIGNED to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation.
- Latency:
  - The last beat is accepted at edge e0. PE(ROWS-1,COLS-1) accumulates it at edge e0+ROWS+COLS-1.
  - done and result_valid rise after edge e0+ROWS+COLS, i.e. 8 cycles for the default 4x4.
  - With k_len==0: done rises 1 cycle after CLEAR and result is all zero.
- result updates only on entry to DONE and otherwise holds its value. result clears in CLEAR.
- The skew and bubble scheme is invariant: in_valid gaps change the timing of done but never change C.

Decomposition:
- Package systolic_pkg holds the FSM state enum (IDLE, CLEAR, STREAM, DRAIN, DONE) and a function computing the drain length ROWS+COLS-1.
- Sub-module systolic_pe:
  - Inputs: a_in, b_in, clear.
  - Outputs: registered a_out, b_out, and acc.
  - Parameters: OP_WIDTH, ACC_WIDTH, SIGNED.
- The top-level block contains the skew shift registers, the beat and drain counters, the FSM and the generate-built PE grid.

Test Plan:
- Identity: defaults, A=I4, B[k][j]=4k+j+1, k_len=4, in_valid held high -> result equals B (C[0][0]=1, C[3][3]=16). done rises exactly 8 cycles after the last accepted beat.
- Bubbles: same stimulus with in_valid toggling 1,0,1,0 -> identical result. done is delayed by the number of bubbles (3); in_ready stays high throughout STREAM.
- Signed: SIGNED=1, all a=-3 (0xFD), all b=5, k_len=4 -> every C = -60 (0xFFFFFFC4). With SIGNED=0 the same bytes give 253*5*4=5060.
- Wrap: ACC_WIDTH=16, all operands 255 unsigned, k_len=2 -> every C = 130050 mod 65536 = 64514 (0xFC02).
- Edge control: k_len=0 -> done after CLEAR+1 with result all zero. A start pulse during STREAM is ignored (beat count unaffected). Back-to-back start from DONE clears result_valid next cycle and produces a fresh, correct result.
- Reset mid-STREAM after 2 of 4 beats -> all outputs 0 next cycle, FSM in IDLE. A subsequent full identity run matches the first scenario.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic tile engine: FSM state encoding
// and the drain-length calculation used to size the flush phase.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   // Zero-injection cycles needed for the last beat to reach the far corner PE.
   function automatic int drain_len(input int rows, input int cols);
      return rows + cols - 1;
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: registers the incoming A/B operands,
// forwards them right/down, and accumulates their product every cycle.
module systolic_pe #(
   parameter int OP_WIDTH  = 8,
   parameter int ACC_WIDTH = 32,
   parameter int SIGNED    = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [OP_WIDTH-1:0]  a_in,
   input  logic [OP_WIDTH-1:0]  b_in,
   output logic [OP_WIDTH-1:0]  a_out,
   output logic [OP_WIDTH-1:0]  b_out,
   output logic [ACC_WIDTH-1:0] acc
);

   localparam int PW  = 2 * OP_WIDTH;
   localparam bit SGN = (SIGNED != 0);

   logic [PW-1:0]        a_ext;
   logic [PW-1:0]        b_ext;
   logic [PW-1:0]        prod;
   logic [ACC_WIDTH-1:0] prod_ext;

   // Operands are widened to the full product width first, so the low PW bits
   // of the multiply are the exact signed or unsigned product.
   assign a_ext = {{OP_WIDTH{SGN & a_out[OP_WIDTH-1]}}, a_out};
   assign b_ext = {{OP_WIDTH{SGN & b_out[OP_WIDTH-1]}}, b_out};
   assign prod  = a_ext * b_ext;

   if (ACC_WIDTH > PW) begin : g_ext
      assign prod_ext = {{(ACC_WIDTH-PW){SGN & prod[PW-1]}}, prod};
   end else begin : g_noext
      assign prod_ext = prod[ACC_WIDTH-1:0];
   end

   // Operand pipeline and wrapping accumulator; clear zeroes the whole PE.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every PE samples
      // its neighbours' pre-edge values, which is what makes the array shift.
      if (reset || clear) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else begin
         a_out <= a_in;
         b_out <= b_in;
         acc   <= acc + prod_ext;
      end
   end

endmodule

// File: rtl/systolic_tile_engine.sv
// ROWS x COLS output-stationary systolic matrix-multiply tile. Streams one A
// column and one B row per accepted beat, skews them into the PE grid, drains
// the pipeline with zeros and presents a frozen accumulator snapshot.
module systolic_tile_engine
   import systolic_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int OP_WIDTH  = 8,
   parameter int ACC_WIDTH = 32,
   parameter int K_WIDTH   = 8,
   parameter int SIGNED    = 0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [K_WIDTH-1:0]                k_len,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [ROWS*OP_WIDTH-1:0]          a_column,
   input  logic [COLS*OP_WIDTH-1:0]          b_row,
   output logic                              busy,
   output logic                              done,
   output logic                              result_valid,
   output logic [ROWS*COLS*ACC_WIDTH-1:0]    result
);

   localparam int DRAIN_LEN = drain_len(ROWS, COLS);
   localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

   state_t               state;
   logic [K_WIDTH-1:0]   k_reg;
   logic [K_WIDTH-1:0]   beat_cnt;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic                 beat;
   logic                 clear_pipe;

   logic [OP_WIDTH-1:0]  a_bus    [ROWS][COLS];
   logic [OP_WIDTH-1:0]  b_bus    [ROWS][COLS];
   logic [ACC_WIDTH-1:0] acc_grid [ROWS][COLS];
   logic [ROWS*COLS*ACC_WIDTH-1:0] acc_flat;

   // in_ready is high exactly in STREAM, so this is the accept condition.
   assign beat       = in_valid && in_ready;
   assign clear_pipe = (state == CLEAR);

   // Tile sequencing with registered handshake/status outputs and snapshot.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         k_reg        <= '0;
         beat_cnt     <= '0;
         drain_cnt    <= '0;
         in_ready     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state        <= CLEAR;
                  k_reg        <= k_len;
                  beat_cnt     <= '0;
                  drain_cnt    <= '0;
                  busy         <= 1'b1;
                  result_valid <= 1'b0;
                  result       <= '0;
               end
            end
            CLEAR: begin
               if (k_reg == '0) begin
                  // Empty tile: accumulators are zero, result stays zero.
                  state        <= DONE;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  result_valid <= 1'b1;
               end else begin
                  state    <= STREAM;
                  in_ready <= 1'b1;
               end
            end
            STREAM: begin
               if (beat) begin
                  if (beat_cnt == k_reg - K_WIDTH'(1)) begin
                     state     <= DRAIN;
                     in_ready  <= 1'b0;
                     drain_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + K_WIDTH'(1);
                  end
               end
            end
            DRAIN: begin
               // DRAIN_LEN zero injections flush the last beat into the far
               // corner PE; the edge after that takes the snapshot.
               if (drain_cnt == DRAIN_W'(DRAIN_LEN)) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  result_valid <= 1'b1;
                  result       <= acc_flat;
               end else begin
                  drain_cnt <= drain_cnt + DRAIN_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // A-side skew: row i is delayed i cycles before entering PE(i,0).
   for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
      logic [OP_WIDTH-1:0] a_inj;
      assign a_inj = beat ? a_column[i*OP_WIDTH +: OP_WIDTH] : '0;
      if (i == 0) begin : g_direct
         assign a_bus[0][0] = a_inj;
      end else begin : g_delay
         logic [OP_WIDTH-1:0] stage [i];
         // Shift the row operand through its i delay stages.
         always_ff @(posedge clk) begin
            // NOTE: the skew stages are reset and cleared like any other
            // state, because an aborted tile must not leak operands into the
            // next one.
            if (reset || clear_pipe) begin
               for (int s = 0; s < i; s++) stage[s] <= '0;
            end else begin
               stage[0] <= a_inj;
               for (int s = 1; s < i; s++) stage[s] <= stage[s-1];
            end
         end
         assign a_bus[i][0] = stage[i-1];
      end
   end

   // B-side skew: column j is delayed j cycles before entering PE(0,j).
   for (genvar j = 0; j < COLS; j++) begin : g_b_skew
      logic [OP_WIDTH-1:0] b_inj;
      assign b_inj = beat ? b_row[j*OP_WIDTH +: OP_WIDTH] : '0;
      if (j == 0) begin : g_direct
         assign b_bus[0][0] = b_inj;
      end else begin : g_delay
         logic [OP_WIDTH-1:0] stage [j];
         // Shift the column operand through its j delay stages.
         always_ff @(posedge clk) begin
            if (reset || clear_pipe) begin
               for (int s = 0; s < j; s++) stage[s] <= '0;
            end else begin
               stage[0] <= b_inj;
               for (int s = 1; s < j; s++) stage[s] <= stage[s-1];
            end
         end
         assign b_bus[0][j] = stage[j-1];
      end
   end

   // PE grid: A flows right along rows, B flows down along columns.
   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         logic [OP_WIDTH-1:0] a_pass;
         logic [OP_WIDTH-1:0] b_pass;

         systolic_pe #(
            .OP_WIDTH  (OP_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .SIGNED    (SIGNED)
         ) u_pe (
            .clk   (clk),
            .reset (reset),
            .clear (clear_pipe),
            .a_in  (a_bus[i][j]),
            .b_in  (b_bus[i][j]),
            .a_out (a_pass),
            .b_out (b_pass),
            .acc   (acc_grid[i][j])
         );

         if (j < COLS - 1) begin : g_a_fwd
            assign a_bus[i][j+1] = a_pass;
         end else begin : g_a_end
            logic [OP_WIDTH-1:0] a_spill_unused;
            assign a_spill_unused = a_pass;
         end

         if (i < ROWS - 1) begin : g_b_fwd
            assign b_bus[i+1][j] = b_pass;
         end else begin : g_b_end
            logic [OP_WIDTH-1:0] b_spill_unused;
            assign b_spill_unused = b_pass;
         end

         assign acc_flat[(i*COLS+j)*ACC_WIDTH +: ACC_WIDTH] = acc_grid[i][j];
      end
   end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed bench for systolic_tile_engine: three instances (unsigned 32-bit,
// signed 32-bit, unsigned 16-bit accumulators) share one stimulus stream.
module tb_systolic_tile_engine;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int OPW  = 8;
   localparam int KW   = 8;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic [KW-1:0] k_len;
   logic in_valid;
   logic [ROWS*OPW-1:0] a_column;
   logic [COLS*OPW-1:0] b_row;

   logic in_ready_u, busy_u, done_u, rv_u;
   logic [ROWS*COLS*32-1:0] result_u;
   logic in_ready_s, busy_s, done_s, rv_s;
   logic [ROWS*COLS*32-1:0] result_s;
   logic in_ready_w, busy_w, done_w, rv_w;
   logic [ROWS*COLS*16-1:0] result_w;

   int checks = 0;
   int errors = 0;

   logic [7:0] a_m [4][4];   // A[i][k]
   logic [7:0] b_m [4][4];   // B[k][j]

   always #5 clk = ~clk;

   systolic_tile_engine dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready_u),
      .a_column(a_column), .b_row(b_row),
      .busy(busy_u), .done(done_u), .result_valid(rv_u), .result(result_u)
   );

   systolic_tile_engine #(.SIGNED(1)) dut_s (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready_s),
      .a_column(a_column), .b_row(b_row),
      .busy(busy_s), .done(done_s), .result_valid(rv_s), .result(result_s)
   );

   systolic_tile_engine #(.ACC_WIDTH(16)) dut_w (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready_w),
      .a_column(a_column), .b_row(b_row),
      .busy(busy_w), .done(done_w), .result_valid(rv_w), .result(result_w)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] fill32(input logic [31:0] v);
      logic [511:0] r;
      for (int n = 0; n < 16; n++) r[n*32 +: 32] = v;
      return r;
   endfunction

   function automatic logic [255:0] fill16(input logic [15:0] v);
      logic [255:0] r;
      for (int n = 0; n < 16; n++) r[n*16 +: 16] = v;
      return r;
   endfunction

   // Reference matrix product over the first k beats, 32-bit unsigned.
   function automatic logic [511:0] model32(input int k);
      logic [511:0] r;
      logic [31:0]  sum;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            sum = 32'd0;
            for (int kk = 0; kk < k; kk++) sum = sum + a_m[i][kk] * b_m[kk][j];
            r[(i*4+j)*32 +: 32] = sum;
         end
      end
      return r;
   endfunction

   task automatic load_identity();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            a_m[i][k] = (i == k) ? 8'd1 : 8'd0;
            b_m[i][k] = 8'(4*i + k + 1);
         end
   endtask

   task automatic load_uniform(input logic [7:0] av, input logic [7:0] bv);
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            a_m[i][k] = av;
            b_m[i][k] = bv;
         end
   endtask

   task automatic drive_beat(input int kk);
      for (int i = 0; i < 4; i++) a_column[i*8 +: 8] = (kk < 4) ? a_m[i][kk] : 8'd0;
      for (int j = 0; j < 4; j++) b_row[j*8 +: 8]    = (kk < 4) ? b_m[kk][j] : 8'd0;
   endtask

   // Start a tile, stream k beats, and wait (bounded) for done.
   task automatic run_tile(input int k, input bit bubbles, input bit start_mid,
                           output int cycles, output int lat);
      int accepted;
      int iter;
      bit took;
      start    = 1'b1;
      k_len    = k[KW-1:0];
      in_valid = 1'b0;
      tick();
      start  = 1'b0;
      cycles = 0;
      checks++;
      if (busy_u !== 1'b1 || in_ready_u !== 1'b0 || rv_u !== 1'b0 || result_u !== '0) begin
         errors++;
         $display("FAIL clear_state: busy=%b in_ready=%b result_valid=%b result_nonzero=%b, want 1 0 0 0",
                  busy_u, in_ready_u, rv_u, |result_u);
      end
      tick();
      cycles   = 1;
      accepted = 0;
      iter     = 0;
      while (accepted < k && iter < 64) begin
         checks++;
         if (in_ready_u !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready: in_ready=%b at stream cycle %0d, want 1", in_ready_u, iter);
         end
         in_valid = bubbles ? (iter % 2 == 0) : 1'b1;
         start    = start_mid && (accepted == 2);
         drive_beat(accepted);
         took = in_valid && in_ready_u;
         tick();
         cycles++;
         iter++;
         if (took) accepted++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      checks++;
      if (accepted != k) begin
         errors++;
         $display("FAIL beat_budget: accepted=%0d want %0d", accepted, k);
      end
      checks++;
      if (in_ready_u !== 1'b0) begin
         errors++;
         $display("FAIL drain_ready: in_ready=%b after last beat, want 0", in_ready_u);
      end
      lat = 0;
      while (done_u !== 1'b1 && lat < 40) begin
         tick();
         lat++;
         cycles++;
      end
      checks++;
      if (done_u !== 1'b1 || rv_u !== 1'b1 || busy_u !== 1'b0) begin
         errors++;
         $display("FAIL done_entry: done=%b result_valid=%b busy=%b, want 1 1 0", done_u, rv_u, busy_u);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; k_len = '0;
      a_column = '0; b_row = '0;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if (in_ready_u !== 1'b0 || busy_u !== 1'b0 || done_u !== 1'b0 || rv_u !== 1'b0 || result_u !== '0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b busy=%b done=%b result_valid=%b result=%h, want all 0",
                  in_ready_u, busy_u, done_u, rv_u, result_u);
      end
   endtask

   task automatic test_identity(input bit bubbles, input bit start_mid, input int want_cycles);
      int cycles, lat;
      logic [511:0] exp32;
      logic [255:0] exp16;
      logic [511:0] held;
      load_identity();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            exp32[(i*4+j)*32 +: 32] = 32'(4*i + j + 1);
            exp16[(i*4+j)*16 +: 16] = 16'(4*i + j + 1);
         end
      run_tile(4, bubbles, start_mid, cycles, lat);
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL identity_latency: %0d cycles after last beat, want 8", lat);
      end
      checks++;
      if (cycles != want_cycles) begin
         errors++;
         $display("FAIL identity_total_cycles: %0d want %0d", cycles, want_cycles);
      end
      checks++;
      if (result_u !== exp32) begin
         errors++;
         $display("FAIL identity_result: got %h want %h", result_u, exp32);
      end
      checks++;
      if (result_u[31:0] !== 32'd1 || result_u[15*32 +: 32] !== 32'd16) begin
         errors++;
         $display("FAIL identity_corners: C00=%0d C33=%0d want 1 16", result_u[31:0], result_u[15*32 +: 32]);
      end
      checks++;
      if (result_s !== exp32 || result_w !== exp16) begin
         errors++;
         $display("FAIL identity_variants: signed=%h acc16=%h", result_s, result_w);
      end
      held = result_u;
      tick();
      checks++;
      if (done_u !== 1'b0 || rv_u !== 1'b1 || result_u !== held) begin
         errors++;
         $display("FAIL done_pulse_hold: done=%b result_valid=%b frozen=%b, want 0 1 1",
                  done_u, rv_u, result_u === held);
      end
   endtask

   task automatic test_signed();
      int cycles, lat;
      load_uniform(8'hFD, 8'd5);
      run_tile(4, 1'b0, 1'b0, cycles, lat);
      checks++;
      if (result_s !== fill32(32'hFFFF_FFC4)) begin
         errors++;
         $display("FAIL signed_result: got %h want all FFFFFFC4", result_s);
      end
      checks++;
      if (result_u !== fill32(32'd5060) || result_w !== fill16(16'd5060)) begin
         errors++;
         $display("FAIL unsigned_same_bytes: got %h / %h want all 5060", result_u, result_w);
      end
   endtask

   task automatic test_wrap();
      int cycles, lat;
      load_uniform(8'hFF, 8'hFF);
      run_tile(2, 1'b0, 1'b0, cycles, lat);
      checks++;
      if (result_w !== fill16(16'hFC02)) begin
         errors++;
         $display("FAIL wrap_acc16: got %h want all FC02", result_w);
      end
      checks++;
      if (result_u !== fill32(32'd130050) || result_s !== fill32(32'd2)) begin
         errors++;
         $display("FAIL wrap_acc32: got %h / %h want all 130050 / all 2", result_u, result_s);
      end
   endtask

   task automatic test_zero_len();
      start = 1'b1;
      k_len = '0;
      tick();
      start = 1'b0;
      checks++;
      if (busy_u !== 1'b1 || rv_u !== 1'b0 || result_u !== '0) begin
         errors++;
         $display("FAIL zero_len_clear: busy=%b result_valid=%b result=%h, want 1 0 0", busy_u, rv_u, result_u);
      end
      tick();
      checks++;
      if (done_u !== 1'b1 || rv_u !== 1'b1 || busy_u !== 1'b0 || in_ready_u !== 1'b0 || result_u !== '0) begin
         errors++;
         $display("FAIL zero_len_done: done=%b result_valid=%b busy=%b in_ready=%b result=%h, want 1 1 0 0 0",
                  done_u, rv_u, busy_u, in_ready_u, result_u);
      end
      tick();
      checks++;
      if (done_u !== 1'b0 || rv_u !== 1'b1) begin
         errors++;
         $display("FAIL zero_len_pulse: done=%b result_valid=%b, want 0 1", done_u, rv_u);
      end
   endtask

   task automatic test_back_to_back();
      int cycles, lat;
      logic [511:0] exp32;
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            a_m[i][k] = 8'(i + 2*k + 1);
            b_m[k][i] = 8'(3*k + i + 2);
         end
      exp32 = model32(4);
      checks++;
      if (rv_u !== 1'b1) begin
         errors++;
         $display("FAIL b2b_precondition: result_valid=%b before restart, want 1", rv_u);
      end
      run_tile(4, 1'b0, 1'b0, cycles, lat);
      checks++;
      if (result_u[31:0] !== 32'd134) begin
         errors++;
         $display("FAIL b2b_c00: got %0d want 134", result_u[31:0]);
      end
      checks++;
      if (result_u !== exp32 || result_s !== exp32) begin
         errors++;
         $display("FAIL b2b_result: got %h want %h", result_u, exp32);
      end
   endtask

   task automatic test_reset_mid();
      load_identity();
      start = 1'b1;
      k_len = 8'd4;
      tick();
      start = 1'b0;
      tick();
      in_valid = 1'b1;
      drive_beat(0);
      tick();
      drive_beat(1);
      tick();
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (in_ready_u !== 1'b0 || busy_u !== 1'b0 || done_u !== 1'b0 || rv_u !== 1'b0 || result_u !== '0) begin
         errors++;
         $display("FAIL reset_mid: in_ready=%b busy=%b done=%b result_valid=%b result=%h, want all 0",
                  in_ready_u, busy_u, done_u, rv_u, result_u);
      end
      tick();
      checks++;
      if (busy_u !== 1'b0 || in_ready_u !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_idle: busy=%b in_ready=%b, want 0 0", busy_u, in_ready_u);
      end
      test_identity(1'b0, 1'b0, 13);
   endtask

   initial begin
      test_reset();
      test_identity(1'b0, 1'b0, 13);   // in_valid held high
      test_identity(1'b1, 1'b0, 16);   // three bubbles
      test_signed();
      test_wrap();
      test_zero_len();
      test_identity(1'b0, 1'b1, 13);   // start pulse mid-stream is ignored
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
